branch_resolve_queue: RTL and testbench

- In-order queue holding in-flight branch predictions between fetch and execute.
- Fetch pushes each control-flow instruction with its PC, the gshare_predictor prediction bit and its target.
- Execute resolves the oldest entry. The block then:
  - drives the predictor update interface (update / update_address / branch_taken / opcode);
  - on a mispredict, flushes the front end with a redirect PC.

---
 rtl/branch_resolve_queue.sv | 189 ++++++++++++++++++
 tb/tb_branch_resolve_queue.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
`default_nettype none
// ============================================================================
// branch_resolve_queue : in-order queue of in-flight branch predictions.
//   Resolves the head, drives predictor updates and mispredict redirects.
//   Optional macro BRQ_STATS_EN adds saturating resolve/mispredict counters.
// Revision: 1.0
// ============================================================================
module branch_resolve_queue #(
  parameter int DEPTH       = 4,
  parameter int ADDR_W      = 8,
  parameter int RECOVER_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [ADDR_W-1:0]       push_pc,
  input  logic                    push_pred,
  input  logic [ADDR_W-1:0]       push_target,
  input  logic [6:0]              push_opcode,
  output logic                    push_ready,
  input  logic                    resolve,
  input  logic                    res_taken,
  output logic                    upd,
  output logic [ADDR_W-1:0]       upd_address,
  output logic                    upd_taken,
  output logic [6:0]              upd_opcode,
  output logic                    mispredict,
  output logic [ADDR_W-1:0]       redirect_pc,
`ifdef BRQ_STATS_EN
  output logic [15:0]             stat_resolved,
  output logic [15:0]             stat_mispred,
`endif
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t state, state_next;
  logic [3:0] rec_cnt, rec_cnt_next;

  logic [ADDR_W-1:0] mem_pc     [DEPTH];
  logic [ADDR_W-1:0] mem_target [DEPTH];
  logic              mem_pred   [DEPTH];
  logic [6:0]        mem_op     [DEPTH];

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count_next;

  logic              op_ok, do_push, do_res, mis, do_write;
  logic [ADDR_W-1:0] head_pc, head_target, fallthru;
  logic              head_pred;
  logic [6:0]        head_op;

  assign op_ok = (push_opcode == OP_BRANCH) || (push_opcode == OP_JALR) ||
                 (push_opcode == OP_JAL);

  // Ready depends on registered state only, so a full queue blocks a push
  // even when the head is popped in the same cycle.
  assign push_ready = (count < CNT_W'(DEPTH)) && (state != RECOVER);
  assign do_push    = push && push_ready && op_ok;
  assign do_res     = resolve && (count != '0);

  assign head_pc     = mem_pc[rd_ptr];
  assign head_target = mem_target[rd_ptr];
  assign head_pred   = mem_pred[rd_ptr];
  assign head_op     = mem_op[rd_ptr];

  assign mis      = do_res && (head_pred != res_taken);
  assign do_write = do_push && !mis;
  assign fallthru = head_pc + ADDR_W'(4);

  always_comb begin
    count_next = count;
    if (mis) begin
      count_next = '0;
    end else begin
      case ({do_write, do_res})
        2'b10:   count_next = count + CNT_W'(1);
        2'b01:   count_next = count - CNT_W'(1);
        default: count_next = count;
      endcase
    end
  end

  always_comb begin
    state_next   = state;
    rec_cnt_next = rec_cnt;
    case (state)
      IDLE: begin
        if (do_write) state_next = BUSY;
      end
      BUSY: begin
        if (mis) begin
          state_next   = RECOVER;
          rec_cnt_next = 4'(RECOVER_CYC);
        end else if (count_next == '0) begin
          state_next = IDLE;
        end
      end
      RECOVER: begin
        if (rec_cnt <= 4'd1) begin
          state_next   = IDLE;
          rec_cnt_next = '0;
        end else begin
          rec_cnt_next = rec_cnt - 4'd1;
        end
      end
      default: begin
        state_next   = IDLE;
        rec_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rec_cnt <= '0;
    end else begin
      state   <= state_next;
      rec_cnt <= rec_cnt_next;
    end
  end

  // Entry payload needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_pc[wr_ptr]     <= push_pc;
      mem_target[wr_ptr] <= push_target;
      mem_pred[wr_ptr]   <= push_pred;
      mem_op[wr_ptr]     <= push_opcode;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      upd         <= 1'b0;
      upd_address <= '0;
      upd_taken   <= 1'b0;
      upd_opcode  <= '0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      count      <= count_next;
      upd        <= do_res;
      mispredict <= mis;
      if (mis) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
        if (do_res)   rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_res) begin
        upd_address <= head_pc;
        upd_taken   <= res_taken;
        upd_opcode  <= head_op;
      end
      if (mis) redirect_pc <= res_taken ? head_target : fallthru;
    end
  end

`ifdef BRQ_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_resolved <= '0;
      stat_mispred  <= '0;
    end else begin
      if (do_res && (stat_resolved != 16'hFFFF)) stat_resolved <= stat_resolved + 16'd1;
      if (mis && (stat_mispred != 16'hFFFF))     stat_mispred  <= stat_mispred + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
`default_nettype none
// Testbench for branch_resolve_queue: directed scenarios plus random traffic
// checked against a queue-based reference model through a scoreboard.
module tb_branch_resolve_queue;

  localparam int DEPTH       = 4;
  localparam int ADDR_W      = 8;
  localparam int RECOVER_CYC = 2;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] JAL  = 7'b1101111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push = 1'b0;
  logic [7:0]  push_pc = '0;
  logic        push_pred = 1'b0;
  logic [7:0]  push_target = '0;
  logic [6:0]  push_opcode = '0;
  logic        push_ready;
  logic        resolve = 1'b0;
  logic        res_taken = 1'b0;
  logic        upd;
  logic [7:0]  upd_address;
  logic        upd_taken;
  logic [6:0]  upd_opcode;
  logic        mispredict;
  logic [7:0]  redirect_pc;
  logic [2:0]  count;
`ifdef BRQ_STATS_EN
  logic [15:0] stat_resolved;
  logic [15:0] stat_mispred;
  int          n_res = 0;
  int          n_mis = 0;
`endif

  always #5 clk = ~clk;

  branch_resolve_queue #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RECOVER_CYC(RECOVER_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .push(push), .push_pc(push_pc), .push_pred(push_pred),
    .push_target(push_target), .push_opcode(push_opcode),
    .push_ready(push_ready),
    .resolve(resolve), .res_taken(res_taken),
    .upd(upd), .upd_address(upd_address), .upd_taken(upd_taken),
    .upd_opcode(upd_opcode), .mispredict(mispredict), .redirect_pc(redirect_pc),
`ifdef BRQ_STATS_EN
    .stat_resolved(stat_resolved), .stat_mispred(stat_mispred),
`endif
    .count(count)
  );

  typedef struct {
    logic [7:0] pc;
    logic       pred;
    logic [7:0] target;
    logic [6:0] opc;
  } ent_t;

  typedef struct {
    logic [7:0] addr;
    logic       taken;
    logic [6:0] opc;
    logic       mis;
    logic [7:0] redir;
  } upd_t;

  ent_t model_q[$];
  upd_t exp_q[$];
  int   rec_left = 0;
  int   total = 0;
  int   bad = 0;
  upd_t mon_u;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model advances as the DUT will at the next edge.
  task automatic step(input logic p, input logic [7:0] pc, input logic pr,
                      input logic [7:0] tg, input logic [6:0] op,
                      input logic r, input logic tk);
    bit   ready, acc, rv, m;
    ent_t h;
    ent_t e;
    upd_t u;
    @(negedge clk);
    ready = (model_q.size() < DEPTH) && (rec_left == 0);
    check("count", int'(count), model_q.size());
    check("push_ready", int'(push_ready), int'(ready));
    push = p; push_pc = pc; push_pred = pr; push_target = tg; push_opcode = op;
    resolve = r; res_taken = tk;
    acc = p && ready && (op == BEQ || op == JALR || op == JAL);
    rv  = r && (model_q.size() > 0);
    m   = 1'b0;
    if (rv) begin
      h       = model_q[0];
      m       = (h.pred != tk);
      u.addr  = h.pc;
      u.taken = tk;
      u.opc   = h.opc;
      u.mis   = m;
      u.redir = tk ? h.target : 8'(h.pc + 8'd4);
      exp_q.push_back(u);
`ifdef BRQ_STATS_EN
      n_res++;
      if (m) n_mis++;
`endif
    end
    if (m) begin
      model_q.delete();
      rec_left = RECOVER_CYC;
    end else begin
      if (rec_left > 0) rec_left--;
      if (rv) void'(model_q.pop_front());
      if (acc) begin
        e.pc = pc; e.pred = pr; e.target = tg; e.opc = op;
        model_q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, 1'b0, 8'd0, 7'd0, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: every upd pulse must match the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        if (upd) begin
          if (exp_q.size() == 0) begin
            check("spurious_upd", int'(upd), 0);
          end else begin
            mon_u = exp_q.pop_front();
            check("upd_address", int'(upd_address), int'(mon_u.addr));
            check("upd_taken", int'(upd_taken), int'(mon_u.taken));
            check("upd_opcode", int'(upd_opcode), int'(mon_u.opc));
            check("mispredict", int'(mispredict), int'(mon_u.mis));
            if (mon_u.mis) check("redirect_pc", int'(redirect_pc), int'(mon_u.redir));
          end
        end else begin
          check("mispredict_without_upd", int'(mispredict), 0);
          if (exp_q.size() > 0) begin
            check("missing_upd", int'(upd), 1);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic model_reset();
    model_q.delete();
    exp_q.delete();
    rec_left = 0;
`ifdef BRQ_STATS_EN
    n_res = 0;
    n_mis = 0;
`endif
  endtask

  initial begin
    bit         p, r, tk, pr;
    logic [6:0] op;
    int         sel;

    #1 rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_count", int'(count), 0);
    check("reset_upd", int'(upd), 0);
    check("reset_mispredict", int'(mispredict), 0);
    check("reset_upd_taken", int'(upd_taken), 0);
    check("reset_upd_address", int'(upd_address), 0);
    check("reset_redirect_pc", int'(redirect_pc), 0);
    check("reset_upd_opcode", int'(upd_opcode), 0);
    rst = 1'b1;

    // Correct taken prediction.
    step(1, 8'd4, 1, 8'd20, BEQ, 0, 0);
    step(0, 8'd0, 0, 8'd0, 7'd0, 1, 1);
    idle(2);

    // Mispredict not-taken: redirect to pc+4, two recovery cycles.
    step(1, 8'd4, 1, 8'd40, BEQ, 0, 0);
    step(0, 8'd0, 0, 8'd0, 7'd0, 1, 0);
    idle(4);

    // Fall-through wraps.
    step(1, 8'hFC, 1, 8'h10, JAL, 0, 0);
    step(0, 8'd0, 0, 8'd0, 7'd0, 1, 0);
    idle(4);

    // Fill, dropped fifth push, drain in order.
    step(1, 8'h10, 0, 8'h80, BEQ, 0, 0);
    step(1, 8'h20, 0, 8'h81, JALR, 0, 0);
    step(1, 8'h30, 0, 8'h82, JAL, 0, 0);
    step(1, 8'h40, 0, 8'h83, BEQ, 0, 0);
    step(1, 8'h50, 0, 8'h84, BEQ, 0, 0);
    step(1, 8'h60, 0, 8'h85, BEQ, 1, 0);
    step(0, 8'd0, 0, 8'd0, 7'd0, 1, 0);
    step(0, 8'd0, 0, 8'd0, 7'd0, 1, 0);
    step(0, 8'd0, 0, 8'd0, 7'd0, 1, 0);
    idle(2);

    // Mispredict flushes younger entries and a same-cycle push; then empty resolve.
    step(1, 8'h60, 1, 8'hA0, BEQ, 0, 0);
    step(1, 8'h70, 1, 8'hB0, BEQ, 0, 0);
    step(1, 8'h80, 1, 8'hC0, BEQ, 1, 0);
    step(0, 8'd0, 0, 8'd0, 7'd0, 1, 1);
    idle(4);

    // Non-control-flow opcode is ignored.
    step(1, 8'h90, 1, 8'h00, 7'b0110011, 0, 0);
    idle(1);

    // Asynchronous reset while count=3 with an update pulse live.
    step(1, 8'h11, 1, 8'h21, BEQ, 0, 0);
    step(1, 8'h12, 0, 8'h22, BEQ, 0, 0);
    step(1, 8'h13, 1, 8'h23, BEQ, 0, 0);
    step(1, 8'h14, 0, 8'h24, JAL, 1, 1);
    @(posedge clk);
    #2;
    push = 1'b0; resolve = 1'b0;
    check("pre_reset_count", int'(count), 3);
    rst = 1'b0;
    #1;
    check("async_reset_count", int'(count), 0);
    check("async_reset_upd", int'(upd), 0);
    check("async_reset_mispredict", int'(mispredict), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      p   = ($urandom_range(0, 99) < 60);
      sel = $urandom_range(0, 9);
      op  = (sel < 4) ? BEQ : (sel < 6) ? JALR : (sel < 8) ? JAL : 7'($urandom);
      pr  = 1'($urandom);
      r   = ($urandom_range(0, 99) < 45);
      if (model_q.size() > 0 && $urandom_range(0, 99) < 75) tk = model_q[0].pred;
      else tk = 1'($urandom);
      step(p, 8'($urandom), pr, 8'($urandom), op, r, tk);
    end
    idle(4);
    check("pending_updates", exp_q.size(), 0);
`ifdef BRQ_STATS_EN
    check("stat_resolved", int'(stat_resolved), n_res);
    check("stat_mispred", int'(stat_mispred), n_mis);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
